// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions: state encoding, sequence length, tap positions and default seed.
// Imported by the pattern source and by the BER checker.
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } prbs_state_e;

    localparam int         PRBS9_LEN    = 511;
    localparam int         PRBS9_TAP_HI = 8;
    localparam int         PRBS9_TAP_LO = 4;
    localparam logic [8:0] PRBS9_SEED   = 9'h1AA;

    // An all-zero seed would lock the LFSR, so it is replaced by the fallback.
    function automatic logic [8:0] prbs9_guard_seed(input logic [8:0] seed,
                                                    input logic [8:0] fallback);
        return (seed == 9'd0) ? fallback : seed;
    endfunction

endpackage

// File: rtl/prbs9_source_if.sv
// Control and symbol-stream bundle of the PRBS9 source; master = source, slave = consumer.
interface prbs9_source_if #(
    parameter int WRAP_W = 16
);
    logic              i_enable;
    logic              i_load;
    logic [8:0]        i_seed;
    logic              o_bit;
    logic              o_valid;
    logic              o_sync;
    logic [WRAP_W-1:0] o_wrap_cnt;
    logic [1:0]        o_state;

    modport master (
        input  i_enable, i_load, i_seed,
        output o_bit, o_valid, o_sync, o_wrap_cnt, o_state
    );

    modport slave (
        output i_enable, i_load, i_seed,
        input  o_bit, o_valid, o_sync, o_wrap_cnt, o_state
    );
endinterface

// File: rtl/prbs9_lfsr.sv
// 9-bit Fibonacci LFSR for x^9+x^5+1 with load, shift enable and MSB output.
module prbs9_lfsr
    import prbs_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_SEED
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [8:0] i_load_value,
    input  logic       i_shift,
    output logic       o_msb
);
    logic [8:0] lfsr_reg;
    logic [8:0] lfsr_next;
    logic [8:0] shifted;

    assign shifted[0] = lfsr_reg[PRBS9_TAP_HI] ^ lfsr_reg[PRBS9_TAP_LO];

    genvar gi;
    generate
        for (gi = 1; gi < 9; gi++) begin : g_shift
            assign shifted[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    always_comb begin
        lfsr_next = lfsr_reg;
        if (i_load) begin
            lfsr_next = i_load_value;
        end else if (i_shift) begin
            lfsr_next = shifted;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign o_msb = lfsr_reg[8];
endmodule

// File: rtl/prbs9_source.sv
// PRBS9 symbol source: one bit per OS_FACTOR clocks with sync pulse, wrap counter and seed reload.
// Optional one-shot bit-error injection is compiled in with PRBS_ERR_INJECT_EN.
module prbs9_source
    import prbs_pkg::*;
#(
    parameter logic [8:0] SEED      = PRBS9_SEED,
    parameter int         OS_FACTOR = 4,
    parameter int         PH_W      = 4,
    parameter int         WRAP_W    = 16
) (
    input  logic           clock,
    input  logic           i_reset,
`ifdef PRBS_ERR_INJECT_EN
    input  logic           i_inject,
`endif
    prbs9_source_if.master bus
);
    prbs_state_e       state_reg, state_next;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [8:0]        sym_idx_reg, sym_idx_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic              bit_reg, bit_next;
    logic              valid_reg, valid_next;
    logic              sync_reg, sync_next;

    logic       lfsr_msb;
    logic       emit_bit;
    logic       advance;
    logic       tick;
    logic [8:0] load_value;

    // The entry cycle into RUN does not count, so a resume costs one idle clock but keeps phase.
    assign advance    = (state_reg == RUN) && bus.i_enable && !bus.i_load;
    assign tick       = advance && (phase_reg == PH_W'(OS_FACTOR - 1));
    assign load_value = prbs9_guard_seed(bus.i_seed, SEED);

    prbs9_lfsr #(.SEED(SEED)) u_lfsr (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_load       (bus.i_load),
        .i_load_value (load_value),
        .i_shift      (tick),
        .o_msb        (lfsr_msb)
    );

`ifdef PRBS_ERR_INJECT_EN
    logic inject_armed_reg, inject_armed_next;

    // A pulse landing on the strobe cycle itself corrupts that strobe.
    assign emit_bit = lfsr_msb ^ (inject_armed_reg | i_inject);

    always_comb begin
        inject_armed_next = inject_armed_reg | i_inject;
        if (bus.i_load || tick) begin
            inject_armed_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            inject_armed_reg <= 1'b0;
        end else begin
            inject_armed_reg <= inject_armed_next;
        end
    end
`else
    assign emit_bit = lfsr_msb;
`endif

    always_comb begin
        state_next = state_reg;
        if (bus.i_load) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                IDLE:    if (bus.i_enable)  state_next = RUN;
                RUN:     if (!bus.i_enable) state_next = IDLE;
                LOAD:    state_next = bus.i_enable ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        phase_next    = phase_reg;
        sym_idx_next  = sym_idx_reg;
        wrap_cnt_next = wrap_cnt_reg;
        bit_next      = bit_reg;
        valid_next    = 1'b0;
        sync_next     = 1'b0;
        if (bus.i_load) begin
            phase_next    = '0;
            sym_idx_next  = '0;
            wrap_cnt_next = '0;
        end else if (tick) begin
            phase_next = '0;
            bit_next   = emit_bit;
            valid_next = 1'b1;
            sync_next  = (sym_idx_reg == 9'd0);
            if (sym_idx_reg == 9'(PRBS9_LEN - 1)) begin
                sym_idx_next = '0;
                if (wrap_cnt_reg != '1) begin
                    wrap_cnt_next = wrap_cnt_reg + 1'b1;
                end
            end else begin
                sym_idx_next = sym_idx_reg + 9'd1;
            end
        end else if (advance) begin
            phase_next = phase_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            sym_idx_reg  <= '0;
            wrap_cnt_reg <= '0;
            bit_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            sync_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            sym_idx_reg  <= sym_idx_next;
            wrap_cnt_reg <= wrap_cnt_next;
            bit_reg      <= bit_next;
            valid_reg    <= valid_next;
            sync_reg     <= sync_next;
        end
    end

    assign bus.o_bit      = bit_reg;
    assign bus.o_valid    = valid_reg;
    assign bus.o_sync     = sync_reg;
    assign bus.o_wrap_cnt = wrap_cnt_reg;
    assign bus.o_state    = state_reg;
endmodule

// File: tb/tb_prbs9_source.sv
// Scoreboard bench for prbs9_source: stimulus queues expected strobes, a monitor pops and compares.
module tb_prbs9_source;
    localparam int         OS      = 4;
    localparam int         WW      = 16;
    localparam logic [8:0] TB_SEED = 9'h1FF;
    // First 24 bits from seed 1FF, bit 1 in the MSB: 111111111 00000 1111 0 11111
    localparam logic [23:0] HAND24 = 24'hFF83DF;

    typedef struct {
        logic b;
        logic sync;
        int   wrap;
        int   abs_cyc;
        int   gap;
    } exp_t;

    logic clock = 1'b0;
    logic i_reset;
`ifdef PRBS_ERR_INJECT_EN
    logic i_inject;
`endif

    prbs9_source_if #(.WRAP_W(WW)) bus ();

    prbs9_source #(
        .SEED      (TB_SEED),
        .OS_FACTOR (OS),
        .PH_W      (4),
        .WRAP_W    (WW)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
`ifdef PRBS_ERR_INJECT_EN
        .i_inject(i_inject),
`endif
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          last_cyc = -1;
    exp_t        q[$];
    logic        gold[1:1100];
    logic [23:0] hand;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic gen_gold(input logic [8:0] seed);
        for (int i = 1; i <= 9; i++) gold[i] = seed[9-i];
        for (int n = 10; n <= 1100; n++) gold[n] = gold[n-9] ^ gold[n-5];
    endtask

    task automatic push_run(input logic [8:0] seed, input int first_idx, input int count,
                            input int first_abs, input int invert_idx);
        exp_t e;
        gen_gold(seed);
        for (int k = first_idx; k < first_idx + count; k++) begin
            e.b = gold[k];
            if (seed == TB_SEED && k <= 24) e.b = hand[24-k];
            if (k == invert_idx) e.b = ~e.b;
            e.sync    = ((k - 1) % 511) == 0;
            e.wrap    = k / 511;
            e.abs_cyc = (first_abs >= 0) ? first_abs + OS * (k - first_idx) : -1;
            e.gap     = (k == first_idx) ? 0 : OS;
            q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL %s: %0d strobes still pending after %0d cycles, required 0", name, q.size(), budget);
            q.delete();
        end
    endtask

    // Monitor: every strobe is matched against the head of the expected queue.
    initial begin
        exp_t e;
        bit   ok;
        int   seen = 0;
        forever begin
            @(negedge clock);
            if (i_reset === 1'b1 && bus.o_valid === 1'b1) begin
                seen++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_strobe: cycle %0d bit=%b, required no strobe", cyc, bus.o_bit);
                end else begin
                    e  = q.pop_front();
                    n_vec++;
                    ok = (bus.o_bit === e.b) && (bus.o_sync === e.sync) &&
                         (bus.o_wrap_cnt === WW'(e.wrap));
                    if (e.abs_cyc >= 0 && cyc != e.abs_cyc) ok = 1'b0;
                    if (e.gap > 0 && cyc - last_cyc != e.gap) ok = 1'b0;
                    if (!ok) begin
                        n_miss++;
                        $display("FAIL strobe: cycle %0d bit=%b sync=%b wrap=%0d gap=%0d, required cycle %0d bit=%b sync=%b wrap=%0d gap=%0d",
                                 cyc, bus.o_bit, bus.o_sync, bus.o_wrap_cnt, cyc - last_cyc,
                                 e.abs_cyc, e.b, e.sync, e.wrap, e.gap);
                    end else begin
                        $display("strobe %0d cycle %0d bit=%b sync=%b wrap=%0d", seen, cyc,
                                 bus.o_bit, bus.o_sync, bus.o_wrap_cnt);
                    end
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        logic pre_valid;
        int   n;
        hand         = HAND24;
        i_reset      = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_load   = 1'b0;
        bus.i_seed   = 9'd0;
`ifdef PRBS_ERR_INJECT_EN
        i_inject     = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_bit",   32'(bus.o_bit),      32'd0);
        check("reset_valid", 32'(bus.o_valid),    32'd0);
        check("reset_sync",  32'(bus.o_sync),     32'd0);
        check("reset_wrap",  32'(bus.o_wrap_cnt), 32'd0);
        check("reset_state", 32'(bus.o_state),    32'd0);

        i_reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle_state", 32'(bus.o_state), 32'd0);

        // Full sequence plus nine bits: sync and wrap on strobe 511/512, repeat of bits 1..9.
        push_run(TB_SEED, 1, 520, cyc + 5, 0);
        bus.i_enable = 1'b1;
        wait_drain(2300, "drain_wrap");
        check("run_state", 32'(bus.o_state),    32'd1);
        check("wrap_one",  32'(bus.o_wrap_cnt), 32'd1);

        // Zero seed load restarts the default sequence and clears the wrap counter.
        push_run(TB_SEED, 1, 30, cyc + 6, 0);
        bus.i_load = 1'b1;
        bus.i_seed = 9'd0;
        @(posedge clock);
        #1;
        check("load_state", 32'(bus.o_state),    32'd2);
        check("load_wrap",  32'(bus.o_wrap_cnt), 32'd0);
        check("load_valid", 32'(bus.o_valid),    32'd0);
        bus.i_load = 1'b0;
        wait_drain(200, "drain_load0");

        push_run(9'h0A5, 1, 20, cyc + 6, 0);
        bus.i_load = 1'b1;
        bus.i_seed = 9'h0A5;
        @(posedge clock);
        #1;
        check("load2_state", 32'(bus.o_state), 32'd2);
        bus.i_load = 1'b0;
        wait_drain(200, "drain_load_a5");

        // Pause mid-symbol: no strobes while low, stream continues at bit 21.
        @(posedge clock);
        #1;
        bus.i_enable = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        check("pause_state", 32'(bus.o_state), 32'd0);
        check("pause_valid", 32'(bus.o_valid), 32'd0);
        push_run(9'h0A5, 21, 20, -1, 0);
        bus.i_enable = 1'b1;
        wait_drain(200, "drain_resume");

        // Asynchronous reset between edges while a strobe is on the outputs.
        push_run(9'h0A5, 41, 10, -1, 0);
        n = 0;
        while (!(q.size() == 1 && bus.o_valid === 1'b1) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        pre_valid = bus.o_valid;
        check("prereset_strobe", 32'(pre_valid), 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        check("areset_valid", 32'(bus.o_valid),    32'd0);
        check("areset_sync",  32'(bus.o_sync),     32'd0);
        check("areset_bit",   32'(bus.o_bit),      32'd0);
        check("areset_state", 32'(bus.o_state),    32'd0);
        check("areset_wrap",  32'(bus.o_wrap_cnt), 32'd0);
        q.delete();
        repeat (2) @(posedge clock);
        #1;
        push_run(TB_SEED, 1, 24, cyc + 5, 0);
        i_reset = 1'b1;
        wait_drain(200, "drain_restart");

`ifdef PRBS_ERR_INJECT_EN
        // Two inject pulses between strobes 19 and 20 flip only bit 20.
        push_run(TB_SEED, 1, 19, cyc + 6, 0);
        bus.i_load = 1'b1;
        bus.i_seed = 9'd0;
        @(posedge clock);
        #1;
        bus.i_load = 1'b0;
        wait_drain(200, "drain_preinject");
        push_run(TB_SEED, 20, 9, -1, 20);
        i_inject = 1'b1;
        @(posedge clock);
        #1;
        i_inject = 1'b0;
        @(posedge clock);
        #1;
        i_inject = 1'b1;
        @(posedge clock);
        #1;
        i_inject = 1'b0;
        wait_drain(200, "drain_inject");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/prbs9_source.md
Name: prbs9_source

Overview:
- PRBS9 pattern source for the TX filter chain, directly upstream of the BER checker and the FIR.
- Emits one pseudo-random bit per symbol period, with a valid strobe every OS_FACTOR clocks. The strobe drives the checker's valid and prbs inputs and the filter's symbol input.
- Also provides a sequence-start sync pulse, a wrap counter and seed reload, so the BER alignment search can be exercised deterministically.

Parameters:
- SEED, 9'h1AA: LFSR value after reset; also replaces any all-zero seed.
- OS_FACTOR, 4: clocks per symbol (oversampling); legal range 2..16.
- PH_W, 4: phase counter width; must satisfy 2^PH_W >= OS_FACTOR.
- WRAP_W, 16: width of the sequence-wrap counter.

Ports:
- clock, in, 1: single system clock; all state on rising edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_enable, in, 1: run when high; freeze all state when low.
- i_load, in, 1: one-cycle request to load i_seed.
- i_seed, in, 9: seed value sampled when i_load=1.
- o_bit, out, 1: current PRBS symbol bit, registered.
- o_valid, out, 1: one-cycle strobe; o_bit is new this cycle.
- o_sync, out, 1: high with o_valid when the emitted bit is symbol index 0 of the 511-bit sequence.
- o_wrap_cnt, out, WRAP_W: completed 511-symbol sequences since reset or load; saturates.
- o_state, out, 2: 0=IDLE, 1=RUN, 2=LOAD (debug).

Behaviour:
- Reset (i_reset=0, async):
  - lfsr=SEED, phase=0, sym_idx=0, wrap_cnt=0, state=IDLE.
  - o_bit=0, o_valid=0, o_sync=0.
- LFSR:
  - Fibonacci, polynomial x^9+x^5+1.
  - Feedback fb = lfsr[8]^lfsr[4]; shift lfsr <= {lfsr[7:0], fb}.
  - The emitted bit is lfsr[8] before the shift.
- FSM transitions:
  - IDLE -> RUN when i_enable=1.
  - RUN -> IDLE when i_enable=0.
  - Any state -> LOAD when i_load=1; i_load has priority over i_enable and over a shift tick in the same cycle.
  - LOAD -> RUN if i_enable=1, else IDLE. LOAD lasts exactly one cycle.
- In LOAD:
  - lfsr <= (i_seed==0) ? SEED : i_seed.
  - phase=0, sym_idx=0, wrap_cnt=0, o_valid=0, o_sync=0.
- In RUN:
  - phase increments each clock.
  - When phase==OS_FACTOR-1 (tick): phase<=0, o_bit<=lfsr[8], lfsr shifts, o_valid<=1, o_sync<=(sym_idx==0).
  - On tick, sym_idx increments, wrapping 510->0. On that wrap, wrap_cnt increments, saturating at all-ones.
  - On non-tick cycles o_valid=0 and o_sync=0; o_bit holds.
- Latency: the first o_valid comes OS_FACTOR clocks after entering RUN from reset or LOAD. The bit emitted is the seed's MSB, and o_sync=1 on that strobe.
- Strobe spacing: exactly OS_FACTOR clocks between strobes in steady RUN.
- In IDLE:
  - lfsr, phase, sym_idx and wrap_cnt hold.
  - o_valid=0 and o_sync=0; o_bit holds.
  - Resuming continues the sequence with no skipped or repeated bit; the remaining phase count is preserved.
- The lfsr never reaches zero: the reset seed, the load guard and the primitive polynomial guarantee it.
- Reset asserted mid-run: immediate return to reset values; no partial strobe.

Optional Feature:
- Macro PRBS_ERR_INJECT_EN.
- Defined:
  - Adds input port i_inject (1 bit).
  - A one-cycle pulse arms a one-shot flag.
  - The next emitted o_bit is inverted, then the flag clears.
  - The LFSR sequence itself is not corrupted.
  - Multiple pulses before the strobe still inject one error. LOAD and reset clear the flag.
- Undefined: port absent, no inversion logic.

Decomposition:
- Package prbs_pkg holds:
  - state encoding constants IDLE/RUN/LOAD;
  - PRBS9 length 511;
  - tap positions 8 and 4;
  - default SEED.
  These are shared with the BER checker.
- One natural sub-module, prbs9_lfsr: a 9-bit register with load, shift enable and MSB output. Phase counter, FSM and counters stay in the top.

Test Plan:
- Reset, then i_enable=1 with SEED=9'h1FF: o_valid at clocks 4, 8, 12, …; first 9 bits are 1; bits 10-13 are 0,0,0,0; o_sync=1 on the first strobe only.
- Run 511 strobes from reset: o_sync=1 on strobe 512; o_wrap_cnt=1 after it; bits 512-520 equal bits 1-9.
- i_load=1 with i_seed=0 during RUN: the next bit sequence equals the reset (SEED) sequence; o_wrap_cnt=0; first strobe arrives 4 clocks after LOAD.
- Drop i_enable for 7 clocks mid-symbol: no strobes while low; concatenated bit stream identical to an uninterrupted run.
- Assert i_reset=0 asynchronously between clock edges during RUN: outputs zero immediately; the restart sequence matches the first test.
- With PRBS_ERR_INJECT_EN, pulse i_inject twice before strobe 20: only bit 20 is inverted versus the golden stream; bit 21 onward matches.
